rps_match_ctrl: RTL and testbench
=================================

// Module: rps_match_ctrl
// PURPOSE
//  Match sequencer for the combinational rock-paper-scissors judge (RPS). Collects one throw per player via
//  valid/ready, presents both to the judge, samples its result, keeps scores and runs a first-to-WIN_SCORE
//  match with per-round timeout (forfeit) and a reveal hold. Sits between player input logic and judge/7-seg.
//  Encoding: throw 00=rock 01=paper 10=scissors 11=invalid; result 00=tie 01=A wins 10=B wins 11=treated as tie.
// PARAMETERS
//  WIN_SCORE   3     rounds needed to win the match (1..2**SCORE_W-1)
//  SCORE_W     4     width of Acounter/Bcounter
//  TIMEOUT_CYC 1000  COLLECT cycles allowed before the round is forced (>=2)
//  REVEAL_CYC  50    cycles the round outcome is held before the next round (>=1)
//  TMR_W       16    width of the shared timeout/reveal counter
// PORTS
//  CLK          in   1        clock, rising edge
//  RST          in   1        asynchronous reset, active high
//  start        in   1        pulse: begin a new match (honoured in IDLE and DONE only)
//  a_valid      in   1        player A offers a_throw
//  a_throw      in   2        player A throw
//  a_ready      out  1        A throw accepted when a_valid & a_ready at a rising edge
//  b_valid      in   1        player B offers b_throw
//  b_throw      in   2        player B throw
//  b_ready      out  1        as a_ready, for B
//  A            out  2        latched A throw driven to judge
//  B            out  2        latched B throw driven to judge
//  result       in   2        judge output for (A,B), combinational
//  Acounter     out  SCORE_W  A rounds won
//  Bcounter     out  SCORE_W  B rounds won
//  round_done   out  1        one-cycle pulse: round scored
//  round_result out  2        outcome of last round (00 tie / 01 A / 10 B), held until next round_done
//  match_over   out  1        high in DONE
//  winner       out  2        01 A / 10 B in DONE, else 00
// BEHAVIOUR
//  RST (async, any state): state=IDLE; all outputs, latched throws, got-flags, timer = 0.
//  States: IDLE, COLLECT, JUDGE, REVEAL, DONE. All outputs registered, except a_ready/b_ready (decoded
//   from state and flags).
//  IDLE/DONE: start -> clear counters, round_result, winner, got-flags, timer; go COLLECT.
//   start elsewhere is ignored.
//  COLLECT: a_ready = !a_got; b_ready = !b_got (both 0 in all other states). A throw is accepted only if
//   valid&ready and throw!=11; it is loaded into A/B and sets the got-flag. A throw of 11 is dropped;
//   ready stays high. Simultaneous A and B acceptance in one cycle is legal. Timer increments each
//   COLLECT cycle.
//   Both flags set (incl. the accepting edge) -> JUDGE.
//   Timer==TIMEOUT_CYC-1 without both throws -> forced round: only A got -> A wins; only B got -> B wins;
//   neither -> tie. Score update as below; go REVEAL without JUDGE. If the last throw arrives on the
//   timeout edge, the throw wins (JUDGE).
//  JUDGE (exactly 1 cycle): A/B stable since previous edge; result sampled at the end edge. 01 -> Acounter+1;
//   10 -> Bcounter+1; 00/11 -> no change, round_result=00. round_result, counters and round_done=1 update
//   on this edge; go REVEAL. Latency: both throws accepted at edge k -> round_done/counters visible after k+1.
//  round_done is high exactly one cycle (the first REVEAL cycle), then auto-clears.
//  REVEAL: timer reset on entry; held REVEAL_CYC cycles. Then Acounter==WIN_SCORE or Bcounter==WIN_SCORE
//   -> DONE (winner set, match_over=1). Otherwise clear got-flags and timer; go COLLECT. A/B keep last values.
//  Counters never exceed WIN_SCORE (no wrap); both cannot reach it in the same round.
//  DONE: counters, winner and round_result hold until start or RST.
// TESTING (bench models the judge: rock>scissors, scissors>paper, paper>rock; invalid/equal -> 00)
//  1 RST mid-REVEAL after A scored -> next cycle all outputs 0, IDLE; a_ready=0 until start.
//  2 start; A=00, B=10 valid the same cycle -> both ready drop; round_done 2 edges later; round_result=01,
//    Acounter=1, Bcounter=0.
//  3 A=01, B=01 -> round_result=00, counters unchanged; a_throw=11 offered first -> ignored, a_ready stays 1.
//  4 only B throws 10; wait TIMEOUT_CYC cycles -> forced round, Bcounter+1, round_result=10, no JUDGE
//    cycle. Neither throws -> round_result=00.
//  5 A wins 3 rounds (WIN_SCORE=3) -> after 3rd REVEAL: match_over=1, winner=01, Acounter=3; a_valid
//    ignored; start -> counters 0, COLLECT.
//  6 start pulsed during COLLECT/REVEAL -> no effect; scores and state unchanged.

Source files
------------

// File: rtl/rps_match_ctrl_if.sv
// rtl/rps_match_ctrl_if.sv - player, judge and score signals of the rock-paper-scissors match sequencer
interface rps_match_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic               a_valid;
    logic [1:0]         a_throw;
    logic               a_ready;
    logic               b_valid;
    logic [1:0]         b_throw;
    logic               b_ready;
    logic [1:0]         A;
    logic [1:0]         B;
    logic [1:0]         result;
    logic [SCORE_W-1:0] Acounter;
    logic [SCORE_W-1:0] Bcounter;
    logic               round_done;
    logic [1:0]         round_result;
    logic               match_over;
    logic [1:0]         winner;

    modport slave (
        input  start, a_valid, a_throw, b_valid, b_throw, result,
        output a_ready, b_ready, A, B, Acounter, Bcounter,
               round_done, round_result, match_over, winner
    );

    modport master (
        output start, a_valid, a_throw, b_valid, b_throw, result,
        input  a_ready, b_ready, A, B, Acounter, Bcounter,
               round_done, round_result, match_over, winner
    );
endinterface

// File: rtl/rps_match_ctrl.sv
// rtl/rps_match_ctrl.sv - first-to-WIN_SCORE rock-paper-scissors match sequencer with timeout forfeit
module rps_match_ctrl #(
    parameter int WIN_SCORE   = 3,
    parameter int SCORE_W     = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int REVEAL_CYC  = 50,
    parameter int TMR_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    rps_match_ctrl_if.slave  bus
);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [TMR_W-1:0]   TO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   RV_LAST = TMR_W'(REVEAL_CYC - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, JUDGE, REVEAL, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         a_q, a_d, b_q, b_d;
    logic               a_got_q, a_got_d, b_got_q, b_got_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [SCORE_W-1:0] acnt_q, acnt_d, bcnt_q, bcnt_d;
    logic               rdone_q, rdone_d;
    logic [1:0]         rres_q, rres_d, win_q, win_d;
    logic               over_q, over_d;
    logic               a_acc, b_acc, a_got_n, b_got_n;

    assign bus.a_ready      = (state_q == COLLECT) && !a_got_q;
    assign bus.b_ready      = (state_q == COLLECT) && !b_got_q;
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.Acounter     = acnt_q;
    assign bus.Bcounter     = bcnt_q;
    assign bus.round_done   = rdone_q;
    assign bus.round_result = rres_q;
    assign bus.match_over   = over_q;
    assign bus.winner       = win_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_got_d = a_got_q;
        b_got_d = b_got_q;
        tmr_d   = tmr_q;
        acnt_d  = acnt_q;
        bcnt_d  = bcnt_q;
        rdone_d = 1'b0;
        rres_d  = rres_q;
        win_d   = win_q;
        over_d  = over_q;
        a_acc   = 1'b0;
        b_acc   = 1'b0;
        a_got_n = a_got_q;
        b_got_n = b_got_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    acnt_d  = '0;
                    bcnt_d  = '0;
                    rres_d  = 2'b00;
                    win_d   = 2'b00;
                    over_d  = 1'b0;
                    a_got_d = 1'b0;
                    b_got_d = 1'b0;
                    tmr_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                // An invalid throw (11) is silently dropped and the player stays ready.
                a_acc   = bus.a_valid && !a_got_q && (bus.a_throw != 2'b11);
                b_acc   = bus.b_valid && !b_got_q && (bus.b_throw != 2'b11);
                a_got_n = a_got_q || a_acc;
                b_got_n = b_got_q || b_acc;
                a_got_d = a_got_n;
                b_got_d = b_got_n;
                if (a_acc) a_d = bus.a_throw;
                if (b_acc) b_d = bus.b_throw;
                tmr_d = tmr_q + 1'b1;
                // A throw landing on the timeout edge still goes to the judge.
                if (a_got_n && b_got_n) begin
                    state_d = JUDGE;
                end else if (tmr_q == TO_LAST) begin
                    tmr_d   = '0;
                    rdone_d = 1'b1;
                    state_d = REVEAL;
                    if (a_got_n) begin
                        rres_d = 2'b01;
                        acnt_d = (acnt_q < WIN) ? acnt_q + 1'b1 : acnt_q;
                    end else if (b_got_n) begin
                        rres_d = 2'b10;
                        bcnt_d = (bcnt_q < WIN) ? bcnt_q + 1'b1 : bcnt_q;
                    end else begin
                        rres_d = 2'b00;
                    end
                end
            end
            JUDGE: begin
                tmr_d   = '0;
                rdone_d = 1'b1;
                state_d = REVEAL;
                case (bus.result)
                    2'b01: begin
                        rres_d = 2'b01;
                        acnt_d = (acnt_q < WIN) ? acnt_q + 1'b1 : acnt_q;
                    end
                    2'b10: begin
                        rres_d = 2'b10;
                        bcnt_d = (bcnt_q < WIN) ? bcnt_q + 1'b1 : bcnt_q;
                    end
                    default: rres_d = 2'b00;
                endcase
            end
            REVEAL: begin
                if (tmr_q == RV_LAST) begin
                    tmr_d = '0;
                    if (acnt_q == WIN) begin
                        win_d   = 2'b01;
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else if (bcnt_q == WIN) begin
                        win_d   = 2'b10;
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        a_got_d = 1'b0;
                        b_got_d = 1'b0;
                        state_d = COLLECT;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= 2'b00;
            b_q     <= 2'b00;
            a_got_q <= 1'b0;
            b_got_q <= 1'b0;
            tmr_q   <= '0;
            acnt_q  <= '0;
            bcnt_q  <= '0;
            rdone_q <= 1'b0;
            rres_q  <= 2'b00;
            win_q   <= 2'b00;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_got_q <= a_got_d;
            b_got_q <= b_got_d;
            tmr_q   <= tmr_d;
            acnt_q  <= acnt_d;
            bcnt_q  <= bcnt_d;
            rdone_q <= rdone_d;
            rres_q  <= rres_d;
            win_q   <= win_d;
            over_q  <= over_d;
        end
    end
endmodule

// File: tb/tb_rps_match_ctrl.sv
// tb/tb_rps_match_ctrl.sv - scoreboard bench for rps_match_ctrl with a behavioural judge
module tb_rps_match_ctrl;
    localparam int WIN = 3;
    localparam int SW  = 4;
    localparam int TO  = 20;
    localparam int RV  = 4;
    localparam int TW  = 16;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    typedef struct {
        logic [1:0]    rr;
        logic [SW-1:0] ac;
        logic [SW-1:0] bc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    rps_match_ctrl_if #(.SCORE_W(SW)) bus ();

    rps_match_ctrl #(
        .WIN_SCORE(WIN), .SCORE_W(SW), .TIMEOUT_CYC(TO), .REVEAL_CYC(RV), .TMR_W(TW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b11 || b == 2'b11 || a == b) return 2'b00;
        if ((a == 2'b00 && b == 2'b10) || (a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b00))
            return 2'b01;
        return 2'b10;
    endfunction

    assign bus.result = judge(bus.A, bus.B);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.round_done) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_round", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_round_result", 32'(bus.round_result), 32'(mon_e.rr));
                chk("sb_acounter", 32'(bus.Acounter), 32'(mon_e.ac));
                chk("sb_bcounter", 32'(bus.Bcounter), 32'(mon_e.bc));
            end
        end
    end

    task automatic wait_collect();
        int n = 0;
        while (!(bus.a_ready && bus.b_ready) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_collect", 32'(n < 200), 32'd1);
    endtask

    task automatic play(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] rr, input int ac, input int bc);
        int n = 0;
        wait_collect();
        sbq.push_back('{rr: rr, ac: SW'(ac), bc: SW'(bc)});
        bus.a_valid = 1'b1; bus.a_throw = a;
        bus.b_valid = 1'b1; bus.b_throw = b;
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        chk("ready_drop", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
        while (!bus.round_done && n < 50) begin
            tick();
            n++;
        end
        chk("judge_latency", 32'(n), 32'd1);
    endtask

    task automatic timeout_round(input logic do_b, input logic [1:0] b,
                                 input logic [1:0] rr, input int ac, input int bc);
        int n = 0;
        wait_collect();
        sbq.push_back('{rr: rr, ac: SW'(ac), bc: SW'(bc)});
        if (do_b) begin
            bus.b_valid = 1'b1; bus.b_throw = b;
            tick();
            bus.b_valid = 1'b0;
            n = 1;
            chk("b_only_ready", {30'd0, bus.a_ready, bus.b_ready}, 32'd2);
        end
        while (!bus.round_done && n < TO + 10) begin
            tick();
            n++;
        end
        chk("timeout_latency", 32'(n), 32'(TO));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a_valid = 1'b0; bus.a_throw = 2'b00;
        bus.b_valid = 1'b0; bus.b_throw = 2'b00;
        tick(); tick();
        chk("reset_outputs", {bus.a_ready, bus.b_ready, bus.A, bus.B, bus.Acounter, bus.Bcounter,
                              bus.round_done, bus.round_result, bus.match_over, bus.winner}, 32'd0);
        rst = 1'b0;
        tick();

        bus.start = 1'b1; tick(); bus.start = 1'b0;
        play(2'b00, 2'b10, 2'b01, 1, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_reveal", {bus.a_ready, bus.b_ready, bus.A, bus.B, bus.Acounter, bus.Bcounter,
                               bus.round_done, bus.round_result, bus.match_over, bus.winner}, 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("idle_no_ready", 32'(bus.a_ready), 32'd0);

        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_collect();
        bus.a_valid = 1'b1; bus.a_throw = 2'b11;
        tick();
        bus.a_valid = 1'b0;
        chk("invalid_dropped", 32'(bus.a_ready), 32'd1);
        play(2'b01, 2'b01, 2'b00, 0, 0);
        timeout_round(1'b1, 2'b10, 2'b10, 0, 1);
        timeout_round(1'b0, 2'b00, 2'b00, 0, 1);

        wait_collect();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("start_in_collect", {30'd0, bus.a_ready, bus.b_ready}, 32'd3);
        play(2'b00, 2'b10, 2'b01, 1, 1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("start_in_reveal", 32'(bus.Acounter), 32'd1);
        play(2'b10, 2'b01, 2'b01, 2, 1);
        play(2'b01, 2'b00, 2'b01, 3, 1);

        n = 0;
        while (!bus.match_over && n < 50) begin
            tick();
            n++;
        end
        chk("match_over", 32'(bus.match_over), 32'd1);
        chk("winner", 32'(bus.winner), 32'd1);
        chk("final_acounter", 32'(bus.Acounter), 32'd3);
        chk("final_bcounter", 32'(bus.Bcounter), 32'd1);
        bus.a_valid = 1'b1; bus.a_throw = 2'b00;
        tick();
        bus.a_valid = 1'b0;
        chk("done_no_ready", 32'(bus.a_ready), 32'd0);
        chk("done_a_held", 32'(bus.A), 32'd1);

        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("restart_counters", {24'd0, bus.Acounter, bus.Bcounter}, 32'd0);
        chk("restart_flags", {28'd0, bus.match_over, bus.winner, bus.a_ready}, 32'd1);
        tick(); tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
